// File: rtl/imm_gen_pipe_if.sv
// Handshake bundle for imm_gen_pipe: upstream instruction channel and downstream result channel.
// slave is the generator side, master is the fetch/consumer side.
interface imm_gen_pipe_if #(
  parameter int XLEN  = 64,
  parameter int TAG_W = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_instr;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_imm;
  logic [2:0]       out_fmt;
  logic             out_illegal;
  logic [TAG_W-1:0] out_tag;

  modport slave (
    input  in_valid, in_instr, in_tag, out_ready,
    output in_ready, out_valid, out_imm, out_fmt, out_illegal, out_tag
  );

  modport master (
    output in_valid, in_instr, in_tag, out_ready,
    input  in_ready, out_valid, out_imm, out_fmt, out_illegal, out_tag
  );
endinterface

// File: rtl/imm_gen_pipe.sv
// RV32I/RV64I immediate generator: combinational decode, registered result, 2-entry skid buffer.
// Optional macro IMM_GEN_PERF_EN adds perf_cnt, a saturating count of output handshakes.
module imm_gen_pipe #(
  parameter int XLEN  = 64,
  parameter int TAG_W = 5
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           flush,
  imm_gen_pipe_if.slave  bus
`ifdef IMM_GEN_PERF_EN
  ,
  output logic [31:0]    perf_cnt
`endif
);

  generate
    if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
      $fatal(1, "imm_gen_pipe: XLEN must be 32 or 64");
    end
  endgenerate

  localparam logic [2:0] FMT_R     = 3'd0;
  localparam logic [2:0] FMT_I     = 3'd1;
  localparam logic [2:0] FMT_S     = 3'd2;
  localparam logic [2:0] FMT_B     = 3'd3;
  localparam logic [2:0] FMT_U     = 3'd4;
  localparam logic [2:0] FMT_J     = 3'd5;
  localparam logic [2:0] FMT_SHAMT = 3'd6;
  localparam logic [2:0] FMT_NONE  = 3'd7;

  typedef struct packed {
    logic signed [XLEN-1:0] imm;
    logic [2:0]             fmt;
    logic                   illegal;
    logic [TAG_W-1:0]       tag;
  } ent_t;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  function automatic ent_t decode(input logic [31:0] ins);
    ent_t               d;
    logic signed [11:0] imm_i;
    logic signed [11:0] imm_s;
    logic signed [12:0] imm_b;
    logic signed [31:0] imm_u;
    logic signed [20:0] imm_j;
    logic               is_shift;
    imm_i    = ins[31:20];
    imm_s    = {ins[31:25], ins[11:7]};
    imm_b    = {ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
    imm_u    = {ins[31:12], 12'b0};
    imm_j    = {ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
    is_shift = (ins[14:12] == 3'b001) || (ins[14:12] == 3'b101);
    d         = '0;
    d.fmt     = FMT_NONE;
    d.illegal = 1'b0;
    case (ins[6:0])
      7'b0110011: d.fmt = FMT_R;
      7'b0010011: begin
        if (is_shift) begin
          d.fmt = FMT_SHAMT;
          if (XLEN == 64) d.imm = XLEN'(ins[25:20]);
          else            d.imm = XLEN'(ins[24:20]);
        end else begin
          d.fmt = FMT_I;
          d.imm = XLEN'(imm_i);
        end
      end
      7'b0000011, 7'b1100111, 7'b1110011: begin
        d.fmt = FMT_I;
        d.imm = XLEN'(imm_i);
      end
      7'b0100011: begin
        d.fmt = FMT_S;
        d.imm = XLEN'(imm_s);
      end
      7'b1100011: begin
        d.fmt = FMT_B;
        d.imm = XLEN'(imm_b);
      end
      7'b0110111, 7'b0010111: begin
        d.fmt = FMT_U;
        d.imm = XLEN'(imm_u);
      end
      7'b1101111: begin
        d.fmt = FMT_J;
        d.imm = XLEN'(imm_j);
      end
      // Word-sized OP-IMM-32 / OP-32 only exist on RV64
      7'b0011011: begin
        if (XLEN == 64) begin
          if (is_shift) begin
            d.fmt = FMT_SHAMT;
            d.imm = XLEN'(ins[24:20]);
          end else begin
            d.fmt = FMT_I;
            d.imm = XLEN'(imm_i);
          end
        end else begin
          d.illegal = 1'b1;
        end
      end
      7'b0111011: begin
        if (XLEN == 64) d.fmt = FMT_R;
        else            d.illegal = 1'b1;
      end
      default: d.illegal = 1'b1;
    endcase
    return d;
  endfunction

  state_t r_state;
  state_t w_state_nxt;
  ent_t   r_out_p1;
  ent_t   r_skid_p1;
  ent_t   w_ent_p0;
  logic   w_in_ready;
  logic   w_out_valid;
  logic   w_accept;
  logic   w_load_dec;
  logic   w_load_skid;
  logic   w_load_skid_to_out;

  // Stage p0: decode of the incoming word
  always_comb begin
    w_ent_p0     = decode(bus.in_instr);
    w_ent_p0.tag = bus.in_tag;
  end

  // Ready and valid decode straight from the state register, never from out_ready
  assign w_in_ready  = (r_state != S_FULL);
  assign w_out_valid = (r_state != S_EMPTY);
  assign w_accept    = bus.in_valid & w_in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_EMPTY;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt        = r_state;
    w_load_dec         = 1'b0;
    w_load_skid        = 1'b0;
    w_load_skid_to_out = 1'b0;
    if (flush) begin
      w_state_nxt = S_EMPTY;
    end else begin
      case (r_state)
        S_EMPTY: begin
          if (w_accept) begin
            w_state_nxt = S_ONE;
            w_load_dec  = 1'b1;
          end
        end
        S_ONE: begin
          if (w_accept && !bus.out_ready) begin
            w_state_nxt = S_FULL;
            w_load_skid = 1'b1;
          end else if (w_accept) begin
            w_load_dec = 1'b1;
          end else if (bus.out_ready) begin
            w_state_nxt = S_EMPTY;
          end
        end
        S_FULL: begin
          if (bus.out_ready) begin
            w_state_nxt        = S_ONE;
            w_load_skid_to_out = 1'b1;
          end
        end
        default: w_state_nxt = S_EMPTY;
      endcase
    end
  end

  // Stage p1: output and skid registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_p1  <= '0;
      r_skid_p1 <= '0;
    end else begin
      if (w_load_dec)              r_out_p1 <= w_ent_p0;
      else if (w_load_skid_to_out) r_out_p1 <= r_skid_p1;
      if (w_load_skid)             r_skid_p1 <= w_ent_p0;
    end
  end

  assign bus.in_ready    = w_in_ready;
  assign bus.out_valid   = w_out_valid;
  assign bus.out_imm     = r_out_p1.imm;
  assign bus.out_fmt     = r_out_p1.fmt;
  assign bus.out_illegal = r_out_p1.illegal;
  assign bus.out_tag     = r_out_p1.tag;

`ifdef IMM_GEN_PERF_EN
  logic [31:0] r_perf_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf_cnt <= '0;
    end else if (w_out_valid && bus.out_ready && (r_perf_cnt != 32'hFFFF_FFFF)) begin
      r_perf_cnt <= r_perf_cnt + 32'd1;
    end
  end

  assign perf_cnt = r_perf_cnt;
`endif

endmodule

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
Pipelined, parametrised immediate generator for the decode stage. Covers all RV32I/RV64I base formats: R, I, shift-amount, S, B, U and J. Takes instructions over a valid/ready handshake and returns the sign-extended immediate, a format code, an illegal flag and a pass-through tag one cycle later. A 2-entry skid buffer lets fetch stream at full rate under downstream backpressure.

Parameters:
XLEN, 64, datapath width; legal values 32 or 64. Any other value is a fatal elaboration error.
TAG_W, 5, width of the sideband tag carried alongside each instruction (e.g. ROB/PC index).

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
flush  input  1  synchronous pipeline flush
in_valid  input  1  upstream instruction valid
in_ready  output  1  block can accept an instruction
in_instr  input  32  raw instruction word
in_tag  input  TAG_W  sideband tag
out_valid  output  1  result valid
out_ready  input  1  downstream accepts result
out_imm  output  XLEN  immediate value
out_fmt  output  3  format: 0 R, 1 I, 2 S, 3 B, 4 U, 5 J, 6 SHAMT, 7 NONE
out_illegal  output  1  opcode unsupported for this XLEN
out_tag  output  TAG_W  tag of the result

Behaviour:
- Decode is combinational on in_instr; the result is registered. Latency is exactly 1 cycle from accept (in_valid & in_ready) to out_valid.
- Opcode map:
  - 0110011: R, imm 0.
  - 0000011, 0010011, 1100111, 1110011: I, sext(instr[31:20]).
  - 0010011 with funct3 001/101: SHAMT, zero-extended shift amount; instr[25:20] when XLEN=64, instr[24:20] when XLEN=32.
  - 0100011: S, sext({instr[31:25], instr[11:7]}).
  - 1100011: B, sext({instr[31], instr[7], instr[30:25], instr[11:8], 0}).
  - 0110111, 0010111: U, sext({instr[31:12], 12'b0}).
  - 1101111: J, sext({instr[31], instr[19:12], instr[20], instr[30:21], 0}).
  - XLEN=64 only: 0011011 is I (SHAMT for funct3 001/101, using instr[24:20]); 0111011 is R. Under XLEN=32 both are illegal.
  - Any other opcode: fmt NONE, imm 0, out_illegal 1. The entry still flows through the pipe.
- Storage: output register (OUT) plus skid register (SKID). States:
  - EMPTY: out_valid=0.
  - ONE: OUT valid, SKID empty.
  - FULL: both valid.
- in_ready = !SKID.valid; it is a pure register output with no combinational path from out_ready.
- Transitions:
  - EMPTY + accept -> ONE.
  - ONE + accept & !out_ready -> FULL, new entry into SKID.
  - ONE + accept & out_ready -> ONE, OUT reloaded.
  - ONE + out_ready & !accept -> EMPTY.
  - FULL + out_ready -> ONE, SKID moves to OUT. No accept is possible in FULL.
- Ordering is strictly FIFO. OUT fields are held stable while out_valid & !out_ready.
- flush: next cycle is EMPTY and in_ready=1. An accept in the same cycle as flush is discarded. flush takes priority over every transition.
- Reset (rst_n low, asynchronous): out_valid=0, out_imm=0, out_fmt=0, out_illegal=0, out_tag=0, SKID cleared, so in_ready=1. Reset mid-stream drops all in-flight entries.

Optional Feature:
IMM_GEN_PERF_EN:
- Defined: adds output port perf_cnt [31:0]. It increments on every output handshake (out_valid & out_ready), saturates at 0xFFFFFFFF, and is cleared by rst_n only, never by flush.
- Undefined: the port and counter are absent, and all other behaviour is identical.

Test Plan:
- Basic decodes, XLEN=64, out_ready=1:
  - ADDI 0xFFF00093 -> out_imm 0xFFFFFFFFFFFFFFFF, fmt 1, one cycle later.
  - BEQ 0xFE000EE3 -> imm 0xFFFFFFFFFFFFFFFC, fmt 3.
  - LUI 0x800002B7 -> imm 0xFFFFFFFF80000000, fmt 4.
- SRAI 0x43F0D093, XLEN=64 -> imm 0x3F, fmt 6. Same word with XLEN=32 -> imm 0x1F.
- Opcode 0x0000007F with tag 0x15 -> out_illegal 1, imm 0, fmt 7, out_tag 0x15. Opcode 0x0000003B under XLEN=32 -> illegal.
- Backpressure: out_ready=0, in_valid held with tags 1,2,3 -> tags 1 and 2 accepted, in_ready=0 from the cycle after tag 2's accept. Then out_ready=1 -> outputs 1,2,3 in order with no gaps. With IMM_GEN_PERF_EN defined, perf_cnt=3.
- FULL state, assert flush together with in_valid -> next cycle out_valid 0, in_ready 1, and the flushed-cycle input never appears.
- rst_n pulsed low mid-stream while FULL -> all outputs 0 and in_ready 1 immediately, with no clock edge required.
